// File: rtl/int_cascade.sv
// Cascade of N_ORDER signed integrators with wrap/saturate arithmetic, clear and fill tracking.
// Define INT_CASCADE_SAT_EN to compile in the saturate datapath and the sticky o_ovf flag.
module int_cascade #(
  parameter int unsigned I_WIDTH = 8,
  parameter int unsigned N_ORDER = 3,
  parameter int unsigned O_WIDTH = 24
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_clr,
  input  logic                      i_sat,
  input  logic signed [I_WIDTH-1:0] i_x,
  output logic signed [O_WIDTH-1:0] o_y,
  output logic                      o_valid,
  output logic                      o_ovf
);

  if (O_WIDTH < I_WIDTH + 1) begin : g_bad_width
    $error("int_cascade: O_WIDTH must be at least I_WIDTH+1");
  end
  if (N_ORDER < 1 || N_ORDER > 8) begin : g_bad_order
    $error("int_cascade: N_ORDER must be in 1..8");
  end

  localparam int unsigned CntW = $clog2(N_ORDER + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(N_ORDER);
  localparam logic signed [O_WIDTH-1:0] AccMax = {1'b0, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [O_WIDTH-1:0] AccMin = {1'b1, {(O_WIDTH-1){1'b0}}};

  logic signed [O_WIDTH-1:0] acc_q   [N_ORDER];
  logic signed [O_WIDTH-1:0] acc_d   [N_ORDER];
  logic signed [O_WIDTH-1:0] acc_upd [N_ORDER];
  logic signed [O_WIDTH:0]   addend  [N_ORDER];
  logic signed [O_WIDTH:0]   sum     [N_ORDER];
  logic [N_ORDER-1:0]        clamp;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;

  // Each stage adds the previous stage's pre-edge register, one guard bit wide.
  always_comb begin
    addend[0] = {{(O_WIDTH + 1 - I_WIDTH){i_x[I_WIDTH-1]}}, i_x};
    for (int k = 1; k < N_ORDER; k++) begin
      addend[k] = {acc_q[k-1][O_WIDTH-1], acc_q[k-1]};
    end
  end

  always_comb begin
    clamp = '0;
    for (int k = 0; k < N_ORDER; k++) begin
      sum[k]     = {acc_q[k][O_WIDTH-1], acc_q[k]} + addend[k];
      acc_upd[k] = sum[k][O_WIDTH-1:0];
`ifdef INT_CASCADE_SAT_EN
      // Guard bit disagreeing with the MSB means the sum left the O_WIDTH range.
      if (i_sat && (sum[k][O_WIDTH] != sum[k][O_WIDTH-1])) begin
        clamp[k]   = 1'b1;
        acc_upd[k] = sum[k][O_WIDTH] ? AccMin : AccMax;
      end
`endif
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (i_clr) begin
      for (int k = 0; k < N_ORDER; k++) begin
        acc_d[k] = '0;
      end
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (i_en) begin
      acc_d = acc_upd;
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
      ovf_d = ovf_q | (|clamp);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_ORDER; k++) begin
        acc_q[k] <= '0;
      end
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_y     = acc_q[N_ORDER-1];
  assign o_valid = (cnt_q == CntMax);

`ifdef INT_CASCADE_SAT_EN
  assign o_ovf = ovf_q;
`else
  logic unused_sig;
  assign unused_sig = ^{i_sat, ovf_q};
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_int_cascade.sv
// Randomized and directed bench for int_cascade: a default 3rd-order/24-bit instance and a
// 1st-order/10-bit instance share stimulus and are checked against an arithmetic model.
module tb_int_cascade;

  logic clk = 1'b0;
  logic rst_n, en, clr, sat;
  logic signed [7:0]  x;
  logic signed [23:0] y3;
  logic signed [9:0]  y2;
  logic v3, o3, v2, o2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef longint arr_t [8];
  arr_t m3_acc, m2_acc;
  int   m3_cnt, m2_cnt;
  bit   m3_ovf, m2_ovf;

`ifdef INT_CASCADE_SAT_EN
  localparam bit SatEn   = 1'b1;
  localparam bit OvfExp  = 1'b1;
  longint sat_exp [7] = '{127, 254, 381, 508, 511, 511, 383};
`else
  localparam bit SatEn   = 1'b0;
  localparam bit OvfExp  = 1'b0;
  longint sat_exp [7] = '{127, 254, 381, 508, -389, -262, -390};
`endif
  longint ramp_exp [7] = '{0, 0, 1, 4, 10, 20, 35};
  longint wrap_exp [5] = '{127, 254, 381, 508, -389};
  longint clr_exp  [3] = '{0, 0, 1};
  longint fill_exp [4] = '{0, 0, 15, 60};

  always #5 clk = ~clk;

  int_cascade #(.I_WIDTH(8), .N_ORDER(3), .O_WIDTH(24)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_sat(sat), .i_x(x),
    .o_y(y3), .o_valid(v3), .o_ovf(o3)
  );

  int_cascade #(.I_WIDTH(8), .N_ORDER(1), .O_WIDTH(10)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_sat(sat), .i_x(x),
    .o_y(y2), .o_valid(v2), .o_ovf(o2)
  );

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint wrap_to(input longint s, input int w);
    longint m, h, r;
    m = longint'(1) <<< w;
    h = m / 2;
    r = (s + h) % m;
    if (r < 0) r += m;
    return r - h;
  endfunction

  // One clock edge of an integrator cascade of order n and width w, from pre-edge values.
  task automatic model_edge(input int n, input int w, input arr_t a, input int c, input bit o,
                            output arr_t an, output int cn, output bit on);
    longint maxv, minv, s, add;
    bit sat_eff;
    an = a;
    cn = c;
    on = o;
    maxv = (longint'(1) <<< (w - 1)) - 1;
    minv = -maxv - 1;
    sat_eff = sat && SatEn;
    if (!rst_n || clr) begin
      for (int k = 0; k < 8; k++) an[k] = 0;
      cn = 0;
      on = 1'b0;
    end else if (en) begin
      for (int k = 0; k < n; k++) begin
        if (k == 0) add = longint'(x);
        else        add = a[k-1];
        s = a[k] + add;
        if (s > maxv || s < minv) begin
          if (sat_eff) begin
            an[k] = (s > maxv) ? maxv : minv;
            on = 1'b1;
          end else begin
            an[k] = wrap_to(s, w);
          end
        end else begin
          an[k] = s;
        end
      end
      cn = (c < n) ? c + 1 : n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge(3, 24, m3_acc, m3_cnt, m3_ovf, m3_acc, m3_cnt, m3_ovf);
    model_edge(1, 10, m2_acc, m2_cnt, m2_ovf, m2_acc, m2_cnt, m2_ovf);
    check_eq("y3", y3, m3_acc[2]);
    check_eq("valid3", v3, m3_cnt == 3);
    check_eq("ovf3", o3, m3_ovf);
    check_eq("y1", y2, m2_acc[0]);
    check_eq("valid1", v2, m2_cnt == 1);
    check_eq("ovf1", o2, m2_ovf);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; sat = 1'b0; x = '0;
    repeat (3) tick();

    rst_n = 1'b1; en = 1'b1; x = 8'sd1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("ramp", y3, ramp_exp[i]);
      check_eq("ramp_valid", v3, i >= 2);
      check_eq("ramp_ovf", o3, 0);
    end

    en = 1'b0;
    repeat (5) begin
      tick();
      check_eq("freeze", y3, 35);
      check_eq("freeze_valid", v3, 1);
    end
    en = 1'b1;
    tick();
    check_eq("resume", y3, 56);

    rst_n = 1'b0; tick();
    rst_n = 1'b1; x = 8'sd127; sat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("wrap1", y2, wrap_exp[i]);
      check_eq("wrap1_ovf", o2, 0);
    end

    rst_n = 1'b0; tick();
    rst_n = 1'b1; sat = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) x = -8'sd128;
      tick();
      check_eq("sat1", y2, sat_exp[i]);
      check_eq("sat1_ovf", o2, (i >= 4) && OvfExp);
    end

    clr = 1'b1; tick();
    check_eq("clr_y3", y3, 0);
    check_eq("clr_y1", y2, 0);
    check_eq("clr_valid3", v3, 0);
    check_eq("clr_valid1", v2, 0);
    check_eq("clr_ovf1", o2, 0);
    clr = 1'b0; sat = 1'b0; x = 8'sd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("clr_ramp", y3, clr_exp[i]);
    end

    rst_n = 1'b0; clr = 1'b1; x = 8'sd15;
    tick();
    check_eq("rst_y3", y3, 0);
    check_eq("rst_valid3", v3, 0);
    check_eq("rst_ovf3", o3, 0);
    rst_n = 1'b1; clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("refill", y3, fill_exp[i]);
    end

    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 999) != 0);
      en    = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 63) == 0) sat = ~sat;
      x = 8'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_cascade.md
# int_cascade

Parametrised cascade of N_ORDER signed integrators for the iCESDM decimation path. It generalises the single first-order integrator to configurable order and accumulator width, adds runtime wrap/saturate arithmetic, a synchronous clear, a sticky overflow flag and a pipeline-fill valid flag. It sits between the modulator bitstream/pre-scaler and the comb/decimator section. Every stage runs on the same clock-enable.

## Interface
- I_WIDTH, 8: input sample width, two's complement.
- N_ORDER, 3: number of cascaded integrator stages. Legal range 1..8.
- O_WIDTH, 24: width of every accumulator and of o_y. O_WIDTH >= I_WIDTH+1 is checked at elaboration.
- i_clk  input  1  single clock; all logic updates on its rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_en  input  1  clock-enable; stages and fill counter update only when high.
- i_clr  input  1  synchronous clear of accumulators, fill counter and o_ovf.
- i_sat  input  1  arithmetic mode: 0 = modular wrap, 1 = saturate.
- i_x  input  I_WIDTH  signed input sample.
- o_y  output  O_WIDTH  signed output; the last stage accumulator.
- o_valid  output  1  high once the pipeline has filled.
- o_ovf  output  1  sticky: a stage has saturated.

## Operation
- Stage 0 update: acc0 <= acc0 + sext(i_x).
- Stage k update (k >= 1): acck <= acck + acc(k-1). The right-hand side uses register values from before the edge, so there is one register per stage.
- o_y = acc(N_ORDER-1), driven directly from the register.
- Arithmetic is done at O_WIDTH+1 bits, then reduced:
  - Wrap mode: the sum is truncated to O_WIDTH. This is the modular behaviour a CIC needs.
  - Saturate mode: a positive overflow clamps to 2^(O_WIDTH-1)-1; a negative overflow clamps to -2^(O_WIDTH-1). Each stage clamps independently.
- o_ovf is set on any enabled cycle in which any stage clamps. It stays set until reset or i_clr.
- Fill counter: width ceil(log2(N_ORDER+1)).
  - Increments on each enabled cycle and saturates at N_ORDER.
  - o_valid = (count == N_ORDER).
- Priority per edge: reset, then i_clr, then i_en.
  - i_clr acts even when i_en = 0.
  - During i_clr, i_x is not accumulated on that edge.
- i_sat is sampled on every enabled edge, so a mode change applies to the next update. Accumulator contents are not altered by the change.
- With i_en = 0, all state holds. o_valid and o_ovf hold too.

## Timing
- Reset (i_rst_n = 0 at an edge):
  - All acc = 0, so o_y = 0.
  - Fill counter = 0, so o_valid = 0.
  - o_ovf = 0.
- Reset asserted mid-operation takes effect at the next edge, regardless of i_en, i_clr or i_x.
- Latency: a change on i_x first affects o_y after N_ORDER enabled edges.
- o_valid rises on the N_ORDER-th enabled edge after reset or clear. No handshake; downstream qualifies o_y with o_valid and i_en.
- Constant i_x = c from a zero state: after n enabled edges, o_y = c·C(n, N_ORDER), modulo or clamped per mode.
- Overflow and clamp are resolved in the same cycle as the update. o_ovf is visible immediately after that edge.
- Simultaneous i_clr and i_en: the clear wins, and the count restarts from 0.

## Configuration
- Macro: INT_CASCADE_SAT_EN.
- Defined:
  - The saturate datapath is compiled in and i_sat selects the mode.
  - o_ovf behaves as specified above.
- Undefined:
  - Wrap only; i_sat is ignored.
  - o_ovf is tied to 0.
  - No clamp comparators are synthesised.

## Test plan
- Defaults, i_rst_n low for 3 edges, then high with i_en = 1 and i_x = 1 -> o_y per edge is 0, 0, 1, 4, 10, 20, 35. o_valid rises on the 3rd edge. o_ovf = 0.
- N_ORDER = 1, O_WIDTH = 10, i_x = 127, i_sat = 0 -> o_y = 127, 254, 381, 508, then -389 (wrap). o_ovf = 0.
- Same stimulus with i_sat = 1 (macro defined) -> the 5th value is 511 and stays at 511. o_ovf = 1 after the 5th edge and remains 1. Then i_x = -128 gives 383.
- Defaults mid-ramp: i_en = 0 for 5 edges -> o_y and o_valid frozen. i_en = 1 -> the ramp resumes exactly where it stopped.
- i_clr pulsed with i_en = 1 while o_y ≠ 0 and o_ovf = 1 -> the next edge gives o_y = 0, o_valid = 0, o_ovf = 0. The ramp restarts at 0, 0, 1.
- i_rst_n low for a single edge during a ramp with i_clr = 1 and i_x = 0x0F -> all outputs are 0 after that edge. Refill then behaves as in scenario 1 with c = 15: o_y = 0, 0, 15, 60.
